// File: rtl/ula_pipe_if.sv
// ula_pipe_if: request/result handshake bundle for ula_pipe.
// master: drives in_valid, S, A, B, R, out_ready; receives in_ready, out_valid, O and flags.
// slave: the ULA side of the same signals.
interface ula_pipe_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   S;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         R;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] O;
  logic         Cout;
  logic         Zero;
  logic         Neg;
  logic         Ovf;
  modport master (
    output in_valid, S, A, B, R, out_ready,
    input  in_ready, out_valid, O, Cout, Zero, Neg, Ovf
  );
  modport slave (
    input  in_valid, S, A, B, R, out_ready,
    output in_ready, out_valid, O, Cout, Zero, Neg, Ovf
  );
endinterface

// File: rtl/ula_pipe.sv
// ula_pipe: two-stage pipelined ULA with valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low), bus (ula_pipe_if.slave: request S/A/B/R,
// result O/Cout/Zero/Neg/Ovf). Optional macro ULA_PIPE_OVF_EN builds signed overflow.
module ula_pipe #(parameter int W = 8) (
  input logic       clk,
  input logic       rst_n,
  ula_pipe_if.slave bus
);
  logic         s1_valid_q, s2_valid_q, s1_adv, s2_adv;
  logic [3:0]   s1_s_q;
  logic [W-1:0] s1_a_q, s1_b_q;
  logic         s1_r_q;
  logic [W-1:0] x, y, o_d, o_q;
  logic [W:0]   tmp;
  logic         cout_d, zero_d, neg_d, ovf_d;
  logic         cout_q, zero_q, neg_q, ovf_q;
  assign s2_adv        = !s2_valid_q || bus.out_ready;
  assign s1_adv        = !s1_valid_q || s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.O         = o_q;
  assign bus.Cout      = cout_q;
  assign bus.Zero      = zero_q;
  assign bus.Neg       = neg_q;
  assign bus.Ovf       = ovf_q;
  // Every arithmetic opcode is x +/- y: S[2:1]==11 selects B as the first operand,
  // S[2] makes the second operand 1, S[1] complements B, S[0] subtracts.
  always_comb begin
    x   = (s1_s_q[2:1] == 2'b11) ? s1_b_q : s1_a_q;
    y   = s1_s_q[2] ? W'(1) : s1_s_q[1] ? ~s1_b_q : s1_b_q;
    tmp = s1_s_q[0] ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    if (s1_s_q[3]) begin
      case (s1_s_q[2:0])
        3'd0: tmp = {1'b0, s1_a_q & s1_b_q};
        3'd1: tmp = {1'b0, ~s1_a_q};
        3'd2: tmp = {1'b0, ~s1_b_q};
        3'd3: tmp = {1'b0, s1_a_q | s1_b_q};
        3'd4: tmp = {1'b0, s1_a_q ^ s1_b_q};
        3'd5: tmp = {1'b0, ~(s1_a_q & s1_b_q)};
        3'd6: tmp = {1'b0, s1_a_q};
        3'd7: tmp = {1'b0, s1_b_q};
      endcase
    end
    o_d    = s1_r_q ? tmp[W-1:0] : '0;
    cout_d = s1_r_q & tmp[W];
    zero_d = s1_r_q & (tmp[W-1:0] == '0);
    neg_d  = s1_r_q & tmp[W-1];
  end
`ifdef ULA_PIPE_OVF_EN
  // Operand signs must match for add (differ for subtract) and the result sign leaves x's.
  assign ovf_d = s1_r_q & !s1_s_q[3] & (tmp[W-1] ^ x[W-1]) & !(x[W-1] ^ y[W-1] ^ s1_s_q[0]);
`else
  assign ovf_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_s_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_r_q     <= 1'b0;
      o_q        <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_s_q <= bus.S;
          s1_a_q <= bus.A;
          s1_b_q <= bus.B;
          s1_r_q <= bus.R;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          o_q    <= o_d;
          cout_q <= cout_d;
          zero_q <= zero_d;
          neg_q  <= neg_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end
endmodule
